// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory with sized, aligned stores and extended loads,
// branch resolution, MEM/WB boundary register and a halted-only debug read port.
module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_MEM_enable,
    input  logic               i_MEM_reg_write,
    input  logic               i_MEM_mem_to_reg,
    input  logic               i_MEM_mem_read,
    input  logic               i_MEM_mem_write,
    input  logic               i_MEM_branch,
    input  logic               i_MEM_zero,
    input  logic [NB_PC-1:0]   i_MEM_branch_addr,
    input  logic [NB_DATA-1:0] i_MEM_alu_result,
    input  logic [NB_DATA-1:0] i_MEM_data_b,
    input  logic [NB_REG-1:0]  i_MEM_selected_reg,
    input  logic               i_MEM_byte_en,
    input  logic               i_MEM_halfword_en,
    input  logic               i_MEM_word_en,
    input  logic               i_MEM_unsigned,
    input  logic               i_MEM_r31_ctrl,
    input  logic [NB_PC-1:0]   i_MEM_pc,
    input  logic               i_debug_read_en,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic               o_MEM_pc_src,
    output logic [NB_PC-1:0]   o_MEM_branch_addr,
    output logic               o_WB_reg_write,
    output logic               o_WB_mem_to_reg,
    output logic [NB_DATA-1:0] o_WB_read_data,
    output logic [NB_DATA-1:0] o_WB_alu_result,
    output logic [NB_REG-1:0]  o_WB_selected_reg,
    output logic               o_WB_r31_ctrl,
    output logic [NB_PC-1:0]   o_WB_pc,
    output logic               o_MEM_misaligned,
    output logic [NB_DATA-1:0] o_debug_data,
    output logic               o_debug_valid
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    logic [NB_ADDR-1:0] word_addr;
    logic [1:0]         byte_off;
    logic               access_word, access_half, misaligned, do_store;
    logic [3:0]         lane_we;
    logic [NB_DATA-1:0] rd_word, wr_data, load_data;
    logic [15:0]        half_v;
    logic [7:0]         byte_v;

    assign o_MEM_pc_src      = i_MEM_branch & i_MEM_zero;
    assign o_MEM_branch_addr = i_MEM_branch_addr;

    assign word_addr = i_MEM_alu_result[NB_ADDR+1:2];
    assign byte_off  = i_MEM_alu_result[1:0];
    assign rd_word   = mem[word_addr];

    // Word wins over halfword over byte; no enable at all also means word.
    assign access_word = i_MEM_word_en | ~(i_MEM_halfword_en | i_MEM_byte_en);
    assign access_half = ~access_word & i_MEM_halfword_en;
    assign misaligned  = (access_word & (byte_off != 2'b00)) | (access_half & byte_off[0]);
    assign do_store    = i_MEM_enable & i_MEM_mem_write & ~misaligned;

    always_comb begin
        lane_we = '0;
        wr_data = '0;
        if (access_word) begin
            lane_we = '1;
            wr_data = i_MEM_data_b;
        end else if (access_half) begin
            lane_we = byte_off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{i_MEM_data_b[15:0]}};
        end else begin
            lane_we = 4'b0001 << byte_off;
            wr_data = {4{i_MEM_data_b[7:0]}};
        end
    end

    always_comb begin
        half_v    = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        byte_v    = '0;
        load_data = '0;
        case (byte_off)
            2'd0: byte_v = rd_word[7:0];
            2'd1: byte_v = rd_word[15:8];
            2'd2: byte_v = rd_word[23:16];
            2'd3: byte_v = rd_word[31:24];
            default: byte_v = '0;
        endcase
        if (access_word)
            load_data = rd_word;
        else if (access_half)
            load_data = i_MEM_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        else
            load_data = i_MEM_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
    end

    // Memory is kept out of the reset domain; reset only gates the write strobe.
    always_ff @(posedge i_clock) begin
        if (!i_reset && do_store) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (lane_we[k])
                    mem[word_addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_WB_reg_write    <= 1'b0;
            o_WB_mem_to_reg   <= 1'b0;
            o_WB_read_data    <= '0;
            o_WB_alu_result   <= '0;
            o_WB_selected_reg <= '0;
            o_WB_r31_ctrl     <= 1'b0;
            o_WB_pc           <= '0;
            o_MEM_misaligned  <= 1'b0;
            o_debug_data      <= '0;
            o_debug_valid     <= 1'b0;
        end else begin
            o_MEM_misaligned <= i_MEM_enable & (i_MEM_mem_read | i_MEM_mem_write) & misaligned;
            o_debug_valid    <= ~i_MEM_enable & i_debug_read_en;
            if (!i_MEM_enable && i_debug_read_en)
                o_debug_data <= mem[i_debug_addr];
            if (i_MEM_enable) begin
                o_WB_reg_write    <= i_MEM_reg_write;
                o_WB_mem_to_reg   <= i_MEM_mem_to_reg;
                o_WB_read_data    <= (i_MEM_mem_read && !misaligned) ? load_data : '0;
                o_WB_alu_result   <= i_MEM_alu_result;
                o_WB_selected_reg <= i_MEM_selected_reg;
                o_WB_r31_ctrl     <= i_MEM_r31_ctrl;
                o_WB_pc           <= i_MEM_pc;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits between the EX/MEM latch and the WB stage.
- Holds the synchronous data memory and performs byte/halfword/word stores and loads with alignment checking and sign/zero extension.
- Resolves the branch decision for IF.
- Registers its results into the MEM/WB boundary and provides a debug memory-read port for the debug unit while the pipeline is halted.

Parameters:
- NB_DATA, 32, data width.
- NB_PC, 32, PC width.
- NB_REG, 5, register index width.
- NB_ADDR, 8, word-address width; memory depth is 2^NB_ADDR words.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_MEM_enable  in  1  pipeline advance enable from the debug unit.
- i_MEM_reg_write  in  1  WB flag, passed through.
- i_MEM_mem_to_reg  in  1  WB flag, passed through.
- i_MEM_mem_read  in  1  load request.
- i_MEM_mem_write  in  1  store request.
- i_MEM_branch  in  1  branch instruction flag.
- i_MEM_zero  in  1  ALU zero flag.
- i_MEM_branch_addr  in  NB_PC  branch target.
- i_MEM_alu_result  in  NB_DATA  byte address, or result for non-memory ops.
- i_MEM_data_b  in  NB_DATA  store data.
- i_MEM_selected_reg  in  NB_REG  destination register.
- i_MEM_byte_en  in  1  byte access.
- i_MEM_halfword_en  in  1  halfword access.
- i_MEM_word_en  in  1  word access.
- i_MEM_unsigned  in  1  zero-extend loads when 1.
- i_MEM_r31_ctrl  in  1  link flag, passed through.
- i_MEM_pc  in  NB_PC  return PC, passed through.
- i_debug_read_en  in  1  debug memory read request.
- i_debug_addr  in  NB_ADDR  debug word address.
- o_MEM_pc_src  out  1  take branch (combinational).
- o_MEM_branch_addr  out  NB_PC  branch target (combinational).
- o_WB_reg_write  out  1  registered.
- o_WB_mem_to_reg  out  1  registered.
- o_WB_read_data  out  NB_DATA  extended load data, registered.
- o_WB_alu_result  out  NB_DATA  registered.
- o_WB_selected_reg  out  NB_REG  registered.
- o_WB_r31_ctrl  out  1  registered.
- o_WB_pc  out  NB_PC  registered.
- o_MEM_misaligned  out  1  one-cycle registered fault pulse.
- o_debug_data  out  NB_DATA  debug read word.
- o_debug_valid  out  1  debug data valid pulse.

Behaviour:
- Reset (asynchronous): every registered output clears to 0 immediately. Memory contents are not reset. A store in a cycle where i_reset is high is discarded.
- Combinational outputs: o_MEM_pc_src = i_MEM_branch & i_MEM_zero. o_MEM_branch_addr = i_MEM_branch_addr. Both are independent of i_MEM_enable.
- Memory organisation: word address = alu_result[NB_ADDR+1:2]; higher address bits are ignored (wrap-around). Lanes are little-endian: lane k = bits 8k+7:8k, selected by alu_result[1:0].
- Access size: exactly one enable is expected. If more than one is set, priority is word > halfword > byte. If none is set, the access is treated as a word access.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Misaligned store: memory is not written; o_MEM_misaligned pulses 1 on the next edge.
- Misaligned load: o_WB_read_data = 0 and o_MEM_misaligned pulses 1.
- Aligned store (enable=1, mem_write=1): on the rising edge, only the addressed lane(s) are written, taken from the low bits of data_b. Byte stores take data_b[7:0]; halfword stores take data_b[15:0] into lanes 0-1 or 2-3. Other lanes are preserved.
- Load: synchronous read of the word. The selected lane(s) are extended per i_MEM_unsigned and registered into o_WB_read_data, giving 1-cycle latency. When mem_read=0, o_WB_read_data = 0.
- Read and write in the same cycle to the same word: the load returns the old contents (read-before-write).
- Pipeline register: when i_MEM_enable=1, all o_WB_* outputs capture their inputs each edge.
- Halt: when i_MEM_enable=0, all o_WB_* hold, memory is not written, and o_MEM_misaligned = 0.
- Debug read: honoured only when i_MEM_enable=0 and i_debug_read_en=1. o_debug_data = mem[i_debug_addr] on the next edge with o_debug_valid=1 for one cycle. Requests while enabled are ignored (valid stays 0) and o_debug_data holds its last value.

Test Plan:
- Reset mid-run: assert i_reset with o_WB_alu_result=0x1234 → all registered outputs read 0 before the next edge; a store issued during reset leaves the memory word unchanged.
- Word store then load: store 0xDEADBEEF at addr 0x10, then word load signed from 0x10 → o_WB_read_data=0xDEADBEEF one cycle after the load.
- Byte/halfword stores and loads:
  - Byte store 0xAB at addr 0x11 over 0x00000000 → word reads 0x0000AB00.
  - Byte load signed from 0x11 → 0xFFFFFFAB; unsigned → 0x000000AB.
  - Halfword store 0x8001 at 0x12 → word reads 0x8001AB00.
- Misalignment: halfword store at 0x13 → memory unchanged, o_MEM_misaligned=1 for one cycle. Word load at 0x12 → o_WB_read_data=0 with the pulse.
- Branch and halt:
  - branch=1, zero=1, branch_addr=0x40 → o_MEM_pc_src=1 and o_MEM_branch_addr=0x40 in the same cycle; branch=1, zero=0 → pc_src=0.
  - With i_MEM_enable=0 and a store asserted → memory unchanged and o_WB_* hold.
- Debug port: halted, debug read of word 4 holding 0xDEADBEEF → o_debug_data=0xDEADBEEF with o_debug_valid high for exactly one cycle. The same request with i_MEM_enable=1 → o_debug_valid stays 0.
